// File: rtl/divide_pkg.sv
// Shared types and sizing helpers for the signed restoring divider sequencer.
package divide_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        TRIAL = 3'd3,
        SIGN  = 3'd4,
        STORE = 3'd5,
        DONE  = 3'd6
    } state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        int unsigned w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/divide_iter_counter.sv
// Iteration counter for the divide sequencer: clear, saturating increment,
// last-iteration flag, and a scan-shift path through all its bits.
module divide_iter_counter
    import divide_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scan_en,
    input  logic scan_bit,
    input  logic clear,
    input  logic incr,
    output logic last,
    output logic msb
);

    logic [CNT_W-1:0] count;

    assign last = (count == CNT_W'(WIDTH - 1));
    assign msb  = count[CNT_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (scan_en) begin
            // Truncating cast keeps the shift legal when CNT_W is 1.
            count <= CNT_W'({count, scan_bit});
        end else if (clear) begin
            count <= '0;
        end else if (incr && !last) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/divide_sequencer.sv
// Control FSM sequencing a WIDTH-slice divider array through one signed
// restoring division: load magnitudes, WIDTH shift/trial steps, sign fix, store.
module divide_sequencer
    import divide_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic Clock,
    input  logic nReset,
    input  logic Test,
    input  logic SDI,
    output logic SDO,
    input  logic Start,
    input  logic Op1_Sign,
    input  logic Op2_Sign,
    input  logic Op2_Zero,
    input  logic Trial_Cout,
    output logic Busy,
    output logic Done,
    output logic Div_Err,
    output logic LOAD_DIVL,
    output logic LOAD_DIVH,
    output logic LOAD_ACC,
    output logic INV_OP1,
    output logic INV_OP2,
    output logic OP1_INV_Cin,
    output logic OP2_INV_Cin,
    output logic DIVH_P,
    output logic RESULT_P,
    output logic INV_RESULT,
    output logic RESULT_INV_Cin,
    output logic INV_REM,
    output logic ACC_INV_Cin,
    output logic STORE_QUOT,
    output logic STORE_REM
);

    state_t state;
    logic   sa;
    logic   sb;
    logic   div_err;
    logic   cnt_last;
    logic   cnt_msb;
    logic   cnt_clear;
    logic   cnt_incr;

    assign cnt_clear = (state == LOAD) && !Test;
    assign cnt_incr  = (state == TRIAL) && !Test;

    divide_iter_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk      (Clock),
        .rst_n    (nReset),
        .scan_en  (Test),
        .scan_bit (state[2]),
        .clear    (cnt_clear),
        .incr     (cnt_incr),
        .last     (cnt_last),
        .msb      (cnt_msb)
    );

    // Scan order: SDI -> state[0..2] -> counter -> sa -> sb -> SDO.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state   <= IDLE;
            sa      <= 1'b0;
            sb      <= 1'b0;
            div_err <= 1'b0;
        end else if (Test) begin
            state <= state_t'({state[1:0], SDI});
            sa    <= cnt_msb;
            sb    <= sa;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        sa      <= Op1_Sign;
                        sb      <= Op2_Sign;
                        div_err <= 1'b0;
                        state   <= LOAD;
                    end
                end
                LOAD: begin
                    if (Op2_Zero) begin
                        div_err <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= SHIFT;
                    end
                end
                SHIFT:   state <= TRIAL;
                TRIAL:   state <= cnt_last ? SIGN : SHIFT;
                SIGN:    state <= STORE;
                STORE:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign SDO     = sb;
    assign Div_Err = div_err;

    // Controls decode straight from the state register, so scan gating and
    // resume-after-scan need no extra output state.
    always_comb begin
        Busy           = 1'b0;
        Done           = 1'b0;
        LOAD_DIVL      = 1'b0;
        LOAD_DIVH      = 1'b0;
        LOAD_ACC       = 1'b0;
        INV_OP1        = 1'b0;
        INV_OP2        = 1'b0;
        OP1_INV_Cin    = 1'b0;
        OP2_INV_Cin    = 1'b0;
        DIVH_P         = 1'b0;
        RESULT_P       = 1'b0;
        INV_RESULT     = 1'b0;
        RESULT_INV_Cin = 1'b0;
        INV_REM        = 1'b0;
        ACC_INV_Cin    = 1'b0;
        STORE_QUOT     = 1'b0;
        STORE_REM      = 1'b0;
        if (!Test) begin
            Busy = (state != IDLE);
            case (state)
                LOAD: begin
                    LOAD_DIVL   = 1'b1;
                    LOAD_DIVH   = 1'b1;
                    LOAD_ACC    = 1'b1;
                    INV_OP1     = sa;
                    OP1_INV_Cin = sa;
                    INV_OP2     = sb;
                    OP2_INV_Cin = sb;
                end
                SHIFT: DIVH_P = 1'b1;
                TRIAL: RESULT_P = Trial_Cout;
                SIGN: begin
                    INV_RESULT     = sa ^ sb;
                    RESULT_INV_Cin = sa ^ sb;
                    INV_REM        = sa;
                    ACC_INV_Cin    = sa;
                end
                STORE: begin
                    STORE_QUOT = 1'b1;
                    STORE_REM  = 1'b1;
                end
                DONE:    Done = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divide_sequencer.sv
// Self-checking bench for divide_sequencer: table vectors, randomized divides
// against a cycle-offset reference model, reset abort and scan chain checks.
module tb_divide_sequencer;
    import divide_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned M = cnt_w(W);
    localparam int unsigned N = 3 + M + 2;

    logic Clock, nReset, Test, SDI, SDO, Start, Op1_Sign, Op2_Sign, Op2_Zero, Trial_Cout;
    logic Busy, Done, Div_Err, LOAD_DIVL, LOAD_DIVH, LOAD_ACC, INV_OP1, INV_OP2;
    logic OP1_INV_Cin, OP2_INV_Cin, DIVH_P, RESULT_P, INV_RESULT, RESULT_INV_Cin;
    logic INV_REM, ACC_INV_Cin, STORE_QUOT, STORE_REM;
    logic [16:0] ctl;

    int n_checks = 0;
    int n_fail   = 0;

    divide_sequencer #(.WIDTH(W)) dut (
        .Clock(Clock), .nReset(nReset), .Test(Test), .SDI(SDI), .SDO(SDO),
        .Start(Start), .Op1_Sign(Op1_Sign), .Op2_Sign(Op2_Sign),
        .Op2_Zero(Op2_Zero), .Trial_Cout(Trial_Cout),
        .Busy(Busy), .Done(Done), .Div_Err(Div_Err),
        .LOAD_DIVL(LOAD_DIVL), .LOAD_DIVH(LOAD_DIVH), .LOAD_ACC(LOAD_ACC),
        .INV_OP1(INV_OP1), .INV_OP2(INV_OP2),
        .OP1_INV_Cin(OP1_INV_Cin), .OP2_INV_Cin(OP2_INV_Cin),
        .DIVH_P(DIVH_P), .RESULT_P(RESULT_P),
        .INV_RESULT(INV_RESULT), .RESULT_INV_Cin(RESULT_INV_Cin),
        .INV_REM(INV_REM), .ACC_INV_Cin(ACC_INV_Cin),
        .STORE_QUOT(STORE_QUOT), .STORE_REM(STORE_REM)
    );

    assign ctl = {Busy, Done, LOAD_DIVL, LOAD_DIVH, LOAD_ACC, INV_OP1, INV_OP2,
                  OP1_INV_Cin, OP2_INV_Cin, DIVH_P, RESULT_P, INV_RESULT,
                  RESULT_INV_Cin, INV_REM, ACC_INV_Cin, STORE_QUOT, STORE_REM};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Expected controls at cycle offset t after the accepted Start edge.
    function automatic logic [16:0] exp_ctl(input int t, input bit sa, input bit sb,
                                            input bit zero, input bit tc);
        int last;
        bit busy, done, ld, divh, resp, sgn, st;
        last = zero ? 1 : 2 * W + 3;
        busy = (t >= 0) && (t <= last);
        done = (t == last);
        ld   = (t == 0);
        divh = !zero && (t >= 1) && (t <= 2 * W) && (t % 2 == 1);
        resp = !zero && (t >= 2) && (t <= 2 * W) && (t % 2 == 0) && tc;
        sgn  = !zero && (t == 2 * W + 1);
        st   = !zero && (t == 2 * W + 2);
        return {busy, done, ld, ld, ld, ld & sa, ld & sb, ld & sa, ld & sb, divh, resp,
                sgn & (sa ^ sb), sgn & (sa ^ sb), sgn & sa, sgn & sa, st, st};
    endfunction

    // Entered and left at a negedge with the DUT idle.
    task automatic run_divide(input bit sa, input bit sb, input bit zero,
                              input logic [W-1:0] tc, input bit poke,
                              output int done_t, output logic [W-1:0] q);
        int last;
        bit trial;
        last   = zero ? 1 : 2 * W + 3;
        done_t = -1;
        q      = '0;
        Start = 1'b1; Op1_Sign = sa; Op2_Sign = sb;
        @(posedge Clock); #1;
        for (int t = 0; t <= last + 1; t++) begin
            trial      = !zero && (t >= 2) && (t <= 2 * W) && (t % 2 == 0);
            Start      = poke && (t == 5);
            Op1_Sign   = 1'($urandom);
            Op2_Sign   = 1'($urandom);
            Op2_Zero   = (t == 0) ? zero : 1'($urandom);
            Trial_Cout = trial ? tc[W - t / 2] : 1'($urandom);
            @(negedge Clock);
            check($sformatf("ctl t=%0d", t), 32'(ctl), 32'(exp_ctl(t, sa, sb, zero, Trial_Cout)));
            check($sformatf("div_err t=%0d", t), 32'(Div_Err), 32'(zero && t >= 1));
            if (Done && done_t < 0) done_t = t;
            if (trial) q = {q[W-2:0], RESULT_P};
            if (t <= last) begin
                @(posedge Clock); #1;
            end
        end
        Start = 1'b0;
    endtask

    typedef struct {
        bit          sa;
        bit          sb;
        bit          zero;
        logic [7:0]  tc;
        bit          poke;
        int          exp_done;
        logic [7:0]  exp_q;
    } vec_t;

    vec_t        vecs[6];
    logic        bits[N + 12];
    logic [2:0]  sign_code;
    int          done_t;
    logic [W-1:0] q;
    logic [W-1:0] a, b, tc;
    int          ma, mb, rem;

    initial begin
        nReset = 1'b0; Test = 1'b0; SDI = 1'b0; Start = 1'b0;
        Op1_Sign = 1'b0; Op2_Sign = 1'b0; Op2_Zero = 1'b0; Trial_Cout = 1'b0;

        vecs[0] = '{0, 0, 0, 8'hB1, 0, 19, 8'hB1};
        vecs[1] = '{1, 0, 0, 8'h5A, 0, 19, 8'h5A};
        vecs[2] = '{1, 1, 0, 8'h0F, 0, 19, 8'h0F};
        vecs[3] = '{0, 1, 1, 8'hFF, 0,  1, 8'h00};
        vecs[4] = '{0, 0, 0, 8'hC3, 1, 19, 8'hC3};
        vecs[5] = '{0, 1, 0, 8'h81, 0, 19, 8'h81};

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("reset ctl", 32'(ctl), 32'd0);
        check("reset div_err", 32'(Div_Err), 32'd0);
        check("reset sdo", 32'(SDO), 32'd0);
        nReset = 1'b1;

        // Scan: random fill, then a resume image of SIGN with sa=1, sb=0.
        sign_code = SIGN;
        for (int i = 0; i < 12; i++) bits[i] = 1'($urandom);
        bits[12] = 1'b0;
        bits[13] = 1'b1;
        for (int i = 0; i < M; i++) bits[14 + i] = 1'b0;
        bits[14 + M] = sign_code[2];
        bits[15 + M] = sign_code[1];
        bits[16 + M] = sign_code[0];
        Test = 1'b1; Start = 1'b1;
        for (int j = 1; j <= N + 12; j++) begin
            SDI = bits[j - 1];
            @(posedge Clock);
            @(negedge Clock);
            check($sformatf("scan ctl j=%0d", j), 32'(ctl), 32'd0);
            if (j >= N) check($sformatf("scan sdo j=%0d", j), 32'(SDO), 32'(bits[j - N]));
        end
        Test = 1'b0; Start = 1'b0; SDI = 1'b0;
        #1;
        for (int t = 2 * W + 1; t <= 2 * W + 4; t++) begin
            check($sformatf("resume ctl t=%0d", t), 32'(ctl), 32'(exp_ctl(t, 1, 0, 0, 0)));
            @(negedge Clock);
        end

        for (int i = 0; i < 6; i++) begin
            run_divide(vecs[i].sa, vecs[i].sb, vecs[i].zero, vecs[i].tc, vecs[i].poke, done_t, q);
            check($sformatf("vec%0d done offset", i), 32'(done_t), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d quotient bits", i), 32'(q), 32'(vecs[i].exp_q));
        end

        // Random signed divides; Trial_Cout comes from a magnitude division model.
        for (int r = 0; r < 8; r++) begin
            a = W'($urandom);
            b = W'($urandom);
            if (b == '0) b = W'(1);
            ma = a[W-1] ? (1 << W) - int'(a) : int'(a);
            mb = b[W-1] ? (1 << W) - int'(b) : int'(b);
            rem = 0;
            for (int i = W - 1; i >= 0; i--) begin
                rem = rem * 2 + ((ma >> i) & 1);
                tc[i] = (rem >= mb);
                if (rem >= mb) rem = rem - mb;
            end
            run_divide(a[W-1], b[W-1], 1'b0, tc, 1'b0, done_t, q);
            check($sformatf("rand%0d done offset", r), 32'(done_t), 32'd19);
            check($sformatf("rand%0d quotient", r), 32'(q), 32'(ma / mb));
        end

        // Reset during iteration 3 aborts to idle with all controls low.
        Start = 1'b1; Op1_Sign = 1'b1; Op2_Sign = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; Op2_Zero = 1'b0;
        repeat (7) @(posedge Clock);
        #1;
        check("midop busy before reset", 32'(Busy), 32'd1);
        check("midop divh_p before reset", 32'(DIVH_P), 32'd1);
        #1 nReset = 1'b0;
        #1;
        check("midop reset ctl", 32'(ctl), 32'd0);
        check("midop reset div_err", 32'(Div_Err), 32'd0);
        check("midop reset sdo", 32'(SDO), 32'd0);
        @(negedge Clock);
        check("midop reset held ctl", 32'(ctl), 32'd0);
        nReset = 1'b1;
        @(negedge Clock);
        check("post reset idle", 32'(ctl), 32'd0);
        run_divide(1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, done_t, q);
        check("post reset done offset", 32'(done_t), 32'd19);
        check("post reset quotient", 32'(q), 32'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/divide_sequencer.md
Name: divide_sequencer

Overview:
- Control FSM that sequences a WIDTH-slice array of the divider bitslice through one signed restoring division.
- Loads operands through the slice negators to form magnitudes, then runs WIDTH shift/trial-subtract iterations.
- Applies sign correction to the quotient and remainder, then stores both into the output registers.
- Sits between the CPU-side start/done handshake and the bitslice control lines; one instance per divider array.

Parameters:
- WIDTH, 8, number of bitslices (operand width in bits), 2..32.

Ports:
- Clock  in  1  system clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Test  in  1  scan enable.
- SDI  in  1  scan data in.
- SDO  out  1  scan data out.
- Start  in  1  request a divide; sampled in IDLE only.
- Op1_Sign  in  1  dividend MSB; sampled in IDLE with Start.
- Op2_Sign  in  1  divisor MSB; sampled in IDLE with Start.
- Op2_Zero  in  1  divisor-is-zero flag from the array; sampled in LOAD.
- Trial_Cout  in  1  carry out of the MSB slice trial subtract; 1 means no borrow.
- Busy  out  1  high in any state other than IDLE.
- Done  out  1  one-cycle completion pulse.
- Div_Err  out  1  divide-by-zero; held until the next accepted Start.
- LOAD_DIVL, LOAD_DIVH, LOAD_ACC  out  1 each  operand load strobes.
- INV_OP1, INV_OP2, OP1_INV_Cin, OP2_INV_Cin  out  1 each  operand negator controls (Cin drives slice 0).
- DIVH_P  out  1  shift DIVH:DIVL left by one.
- RESULT_P  out  1  commit trial difference into DIVH and shift the quotient bit in.
- INV_RESULT, RESULT_INV_Cin, INV_REM, ACC_INV_Cin  out  1 each  sign-correction controls.
- STORE_QUOT, STORE_REM  out  1 each  output register strobes.

Behaviour:
- Reset: state IDLE, iteration counter 0, latched signs 0. All outputs 0, including Div_Err and SDO=0.
- Reset mid-operation aborts immediately to IDLE; no STORE is issued.
- States: IDLE, LOAD, SHIFT, TRIAL, SIGN, STORE, DONE.
- IDLE: when Start=1 and Test=0, latch sa=Op1_Sign and sb=Op2_Sign, clear Div_Err, go to LOAD. Otherwise stay in IDLE.
- Start while Busy=1 is ignored.
- LOAD (1 cycle):
  - LOAD_DIVL=1, LOAD_ACC=1, LOAD_DIVH=1 (DIVH cleared).
  - INV_OP1=OP1_INV_Cin=sa; INV_OP2=OP2_INV_Cin=sb.
  - If Op2_Zero=1: set Div_Err, go to DONE. Otherwise clear the counter and go to SHIFT.
- SHIFT (1 cycle): DIVH_P=1; go to TRIAL.
- TRIAL (1 cycle):
  - RESULT_P=Trial_Cout (Mealy, combinational from the input); the quotient bit equals Trial_Cout.
  - If counter==WIDTH-1, go to SIGN. Otherwise increment the counter and go to SHIFT.
- SIGN (1 cycle): INV_RESULT=RESULT_INV_Cin=sa^sb; INV_REM=ACC_INV_Cin=sa. The remainder takes the dividend's sign.
- STORE (1 cycle): STORE_QUOT=1, STORE_REM=1; go to DONE.
- DONE (1 cycle): Done=1; go to IDLE.
- Any control output not listed for a state is 0.
- Latency: Start sampled at edge k gives LOAD at edge k, iteration i SHIFT at k+1+2i, TRIAL at k+2+2i, SIGN at k+2W+1, STORE at k+2W+2, DONE at k+2W+3, and IDLE at k+2W+4.
  - Busy is high from k to k+2W+3.
  - WIDTH=8: Done occurs at edge k+19.
- Divide-by-zero: Done at edge k+1 (LOAD→DONE); no STORE; Div_Err=1.
- Counter: clog2(WIDTH) bits; no wrap in normal operation.
- Scan, Test=1:
  - State, counter, sa and sb form a shift chain SDI→state→counter→sa→sb→SDO, shifting every clock.
  - All control outputs are forced to 0 while Test=1; Start is ignored.
  - On return to Test=0, the scanned state is resumed.

Decomposition:
- Package divide_pkg: state enum (3-bit), WIDTH_DEFAULT constant, CNT_W=$clog2(WIDTH) function.
- Sub-module divide_iter_counter: clear, increment, last-flag and scan-shift.
- FSM and output decode live in divide_sequencer.

Test Plan:
- Unsigned divide, WIDTH=8, Start with signs 0,0 and Trial_Cout pattern 1,0,1,1,0,0,0,1 → RESULT_P matches the pattern in the TRIAL cycles; INV_RESULT=0 in SIGN; STORE strobes at k+18; Done at k+19 only.
- Signed operands sa=1, sb=0 → INV_OP1=OP1_INV_Cin=1 in LOAD; INV_RESULT=RESULT_INV_Cin=1 and INV_REM=ACC_INV_Cin=1 in SIGN. With sa=1, sb=1 → INV_RESULT=0, INV_REM=1.
- Op2_Zero=1 in LOAD → Done at k+1, Div_Err=1, no STORE_QUOT/STORE_REM pulse; Div_Err clears on the next Start.
- Start pulsed at k+5 during busy → ignored, Done still at k+19; back-to-back Start at k+20 is accepted.
- nReset low during iteration 3 → all outputs 0 immediately and state IDLE; the following Start runs the full 19-cycle sequence.
- Test=1, shift a known pattern into SDI for 3+CNT_W+2 clocks → the pattern appears on SDO with that latency; all control outputs stay 0 throughout.
